// File: rtl/gb_timer_pkg.sv
// gb_timer_pkg: register addresses, FSM states and TAC tap decode shared by the
// DMG timer block and its divider.
package gb_timer_pkg;
   localparam logic [15:0] ADDR_DIV  = 16'hFF04;
   localparam logic [15:0] ADDR_TIMA = 16'hFF05;
   localparam logic [15:0] ADDR_TMA  = 16'hFF06;
   localparam logic [15:0] ADDR_TAC  = 16'hFF07;

   typedef enum logic [1:0] {RUN, DELAY, RELOAD} timer_state_t;

   function automatic logic [3:0] tac_tap(input logic [1:0] sel);
      return sel == 2'd0 ? 4'd9 : sel == 2'd1 ? 4'd3 : sel == 2'd2 ? 4'd5 : 4'd7;
   endfunction
endpackage

// File: rtl/gb_div_counter.sv
// gb_div_counter: free-running 16-bit system counter behind DIV, exposing the
// upper byte and the TAC-selected tap bit.
module gb_div_counter
   import gb_timer_pkg::*;
(
   input  logic       cpu_clock,
   input  logic       rst,
   input  logic       clr_i,
   input  logic [1:0] sel_i,
   output logic [7:0] div_o,
   output logic       tap_o
);
   logic [15:0] cnt_q, cnt_d;

   assign cnt_d = clr_i ? '0 : cnt_q + 16'd1;

   always_ff @(posedge cpu_clock) cnt_q <= rst ? '0 : cnt_d;

   assign div_o = cnt_q[15:8];
   assign tap_o = cnt_q[tac_tap(sel_i)];
endmodule

// File: rtl/gb_timer.sv
// gb_timer: DMG DIV/TIMA/TMA/TAC registers with falling-edge TIMA clocking,
// delayed overflow reload and one-cycle timer interrupt request.
module gb_timer
   import gb_timer_pkg::*;
#(
   parameter int OVF_DELAY = 4
) (
   input  logic        cpu_clock,
   input  logic        rst,
   input  logic [15:0] addr_bus,
   input  logic [7:0]  data_in,
   input  logic        we,
   output logic [7:0]  data_out,
   output logic        hit,
   output logic        irq_timer
);
   localparam int DW = $clog2(OVF_DELAY + 1);

   timer_state_t  state_q, state_d;
   logic [DW-1:0] dly_q, dly_d;
   logic [7:0]    tima_q, tima_d, tma_q, tma_d, div;
   logic [2:0]    tac_q, tac_d;
   logic          tick_q, tick_src, fall, tap;
   logic          wr_div, wr_tima, wr_tma, wr_tac;

   assign wr_div  = we && addr_bus == ADDR_DIV;
   assign wr_tima = we && addr_bus == ADDR_TIMA;
   assign wr_tma  = we && addr_bus == ADDR_TMA;
   assign wr_tac  = we && addr_bus == ADDR_TAC;

   gb_div_counter u_div (
      .cpu_clock(cpu_clock),
      .rst      (rst),
      .clr_i    (wr_div),
      .sel_i    (tac_q[1:0]),
      .div_o    (div),
      .tap_o    (tap)
   );

   // DIV-clear and TAC glitches come for free from this single edge detector
   assign tick_src = tac_q[2] & tap;
   assign fall     = tick_q & ~tick_src;
   assign tma_d    = wr_tma ? data_in : tma_q;
   assign tac_d    = wr_tac ? data_in[2:0] : tac_q;

   always_comb begin
      state_d = state_q;
      tima_d  = tima_q;
      dly_d   = dly_q;
      case (state_q)
         RUN: begin
            if (wr_tima) tima_d = data_in;
            else if (fall && tima_q == 8'hFF) begin
               tima_d  = 8'h00;
               state_d = DELAY;
               dly_d   = DW'(OVF_DELAY - 1);
            end else if (fall) tima_d = tima_q + 8'd1;
         end
         DELAY: begin
            if (wr_tima) begin
               tima_d  = data_in;
               state_d = RUN;
            end else if (dly_q == '0) state_d = RELOAD;
            else dly_d = dly_q - DW'(1);
         end
         RELOAD: begin
            tima_d  = tma_d;
            state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge cpu_clock) begin
      if (rst) begin
         state_q <= RUN;
         dly_q   <= '0;
         tima_q  <= '0;
         tma_q   <= '0;
         tac_q   <= '0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dly_q   <= dly_d;
         tima_q  <= tima_d;
         tma_q   <= tma_d;
         tac_q   <= tac_d;
         tick_q  <= tick_src;
      end
   end

   // during RELOAD TIMA already shows the value it is about to take
   assign irq_timer = state_q == RELOAD;
   assign hit       = addr_bus[15:2] == ADDR_DIV[15:2];
   assign data_out  = !hit                  ? 8'hFF :
                      addr_bus[1:0] == 2'd0 ? div :
                      addr_bus[1:0] == 2'd1 ? (state_q == RELOAD ? tma_q : tima_q) :
                      addr_bus[1:0] == 2'd2 ? tma_q : {5'b11111, tac_q};
endmodule

// File: tb/tb_gb_timer.sv
// tb_gb_timer: directed and randomized checks of gb_timer against a cycle-counted
// behavioural model of the DMG timer rules.
module tb_gb_timer;
   logic        cpu_clock = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] addr = 16'hFF07;
   logic [7:0]  din = 8'h00;
   logic        we = 1'b0;
   logic [7:0]  data_out;
   logic        hit, irq_timer;

   int tests = 0;
   int fails = 0;

   logic [15:0] m_sys;
   logic [7:0]  m_tima, m_tma;
   logic [2:0]  m_tac;
   bit          m_prev;
   int          c = 0;
   int          wrap_at = -1;
   int          taps[4] = '{9, 3, 5, 7};

   gb_timer #(.OVF_DELAY(4)) dut (
      .cpu_clock(cpu_clock),
      .rst      (rst),
      .addr_bus (addr),
      .data_in  (din),
      .we       (we),
      .data_out (data_out),
      .hit      (hit),
      .irq_timer(irq_timer)
   );

   always #10 cpu_clock = ~cpu_clock;

   function automatic logic [7:0] m_tima_view();
      int d = c - wrap_at;
      if (wrap_at >= 0 && d == 5) return m_tma;
      if (wrap_at >= 0) return 8'h00;
      return m_tima;
   endfunction

   function automatic logic [7:0] m_read(input logic [15:0] a);
      case (a)
         16'hFF04: return m_sys[15:8];
         16'hFF05: return m_tima_view();
         16'hFF06: return m_tma;
         16'hFF07: return {5'b11111, m_tac};
         default:  return 8'hFF;
      endcase
   endfunction

   function automatic bit m_irq();
      return wrap_at >= 0 && c - wrap_at == 5;
   endfunction

   // overflow is tracked as the cycle number of the wrap; delay and reload are offsets from it
   task automatic model_step();
      bit tick;
      int d;
      if (rst) begin
         m_sys = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_prev = 0; wrap_at = -1;
      end else begin
         tick = m_tac[2] && ((m_sys >> taps[m_tac[1:0]]) & 16'd1) != 16'd0;
         d = c - wrap_at;
         if (wrap_at >= 0 && d == 5) begin
            m_tima = (we && addr == 16'hFF06) ? din : m_tma;
            wrap_at = -1;
         end else if (wrap_at >= 0) begin
            if (we && addr == 16'hFF05) begin
               m_tima = din;
               wrap_at = -1;
            end
         end else if (we && addr == 16'hFF05) m_tima = din;
         else if (m_prev && !tick) begin
            if (m_tima == 8'hFF) begin
               m_tima = 8'h00;
               wrap_at = c;
            end else m_tima = m_tima + 8'd1;
         end
         if (we && addr == 16'hFF06) m_tma = din;
         if (we && addr == 16'hFF07) m_tac = din[2:0];
         m_sys = (we && addr == 16'hFF04) ? 16'h0000 : m_sys + 16'd1;
         m_prev = tick;
      end
      c++;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge cpu_clock);
      model_step();
      #1;
      we = 1'b0;
      chk("cyc_rd", data_out, m_read(addr));
      chk("cyc_hit", {7'd0, hit}, {7'd0, addr[15:2] == 14'h3FC1});
      chk("cyc_irq", {7'd0, irq_timer}, {7'd0, m_irq()});
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      addr = a; din = d; we = 1'b1;
      cyc();
   endtask

   task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
      addr = a;
      #1;
      chk(tag, data_out, exp);
      chk({tag, "_model"}, data_out, m_read(a));
   endtask

   task automatic wait_wrap();
      int n = 0;
      while (wrap_at < 0 && n < 64) begin
         cyc();
         n++;
      end
      tests++;
      assert (wrap_at >= 0) else begin
         fails++;
         $error("FAIL wrap_timeout observed=none expected=overflow");
      end
   endtask

   task automatic wait_sys8();
      int n = 0;
      while (m_sys[3:0] != 4'h8 && n < 32) begin
         cyc();
         n++;
      end
   endtask

   initial begin
      cyc();
      cyc();
      rst = 1'b0;
      rd("rst_div", 16'hFF04, 8'h00);
      rd("rst_tima", 16'hFF05, 8'h00);
      rd("rst_tma", 16'hFF06, 8'h00);
      rd("rst_tac", 16'hFF07, 8'hF8);
      rd("miss", 16'h1234, 8'hFF);
      chk("miss_hit", {7'd0, hit}, 8'h00);
      chk("rst_irq", {7'd0, irq_timer}, 8'h00);

      for (int i = 0; i < 256; i++) begin
         addr = 16'hFF00 + 16'($urandom_range(15));
         cyc();
      end
      rd("div_256", 16'hFF04, 8'h01);
      for (int i = 256; i < 65536; i++) begin
         addr = 16'hFF00 + 16'($urandom_range(15));
         cyc();
      end
      rd("div_wrap", 16'hFF04, 8'h00);

      wr(16'hFF07, 8'h05);
      wr(16'hFF05, 8'h00);
      repeat (160) cyc();
      rd("tima_count", 16'hFF05, 8'h0A);

      wr(16'hFF06, 8'hAB);
      wr(16'hFF05, 8'hFF);
      addr = 16'hFF05;
      wait_wrap();
      for (int i = 0; i < 4; i++) begin
         rd("ovf_zero", 16'hFF05, 8'h00);
         chk("ovf_no_irq", {7'd0, irq_timer}, 8'h00);
         cyc();
      end
      rd("ovf_reload", 16'hFF05, 8'hAB);
      chk("ovf_irq", {7'd0, irq_timer}, 8'h01);
      cyc();
      rd("ovf_after", 16'hFF05, 8'hAB);
      chk("ovf_irq_end", {7'd0, irq_timer}, 8'h00);

      wr(16'hFF05, 8'hFF);
      addr = 16'hFF05;
      wait_wrap();
      cyc();
      wr(16'hFF05, 8'h10);
      for (int i = 0; i < 6; i++) begin
         rd("cancel_tima", 16'hFF05, 8'h10);
         chk("cancel_irq", {7'd0, irq_timer}, 8'h00);
         cyc();
      end

      wait_sys8();
      wr(16'hFF05, 8'h20);
      wr(16'hFF04, 8'h00);
      cyc();
      rd("glitch_div", 16'hFF05, 8'h21);
      wait_sys8();
      wr(16'hFF05, 8'h20);
      wr(16'hFF07, 8'h01);
      cyc();
      rd("glitch_tac", 16'hFF05, 8'h21);
      rd("tac_read", 16'hFF07, 8'hF9);

      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(15);
         addr = 16'hFF00 + 16'($urandom_range(15));
         din = 8'($urandom);
         if ($urandom_range(3) == 0) begin
            we = 1'b1;
            addr = r == 0 ? 16'hFF04 : r < 6 ? 16'hFF05 : r < 9 ? 16'hFF06 : 16'hFF07;
            if (r >= 1 && r < 6 && $urandom_range(1) == 1) din = 8'hF0 | 8'($urandom_range(15));
            if (r >= 9 && $urandom_range(7) != 0) din = 8'h05;
         end
         cyc();
      end

      wr(16'hFF07, 8'h00);
      repeat (8) cyc();
      wr(16'hFF07, 8'h05);
      wr(16'hFF05, 8'hFF);
      wait_wrap();
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      rd("rst_dly_tima", 16'hFF05, 8'h00);
      rd("rst_dly_div", 16'hFF04, 8'h00);
      rd("rst_dly_tac", 16'hFF07, 8'hF8);
      for (int i = 0; i < 8; i++) begin
         chk("rst_dly_irq", {7'd0, irq_timer}, 8'h00);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/gb_timer.md
# gb_timer

Game Boy timer/divider unit: implements DIV (FF04), TIMA (FF05), TMA (FF06) and TAC (FF07) on the CPU bus and produces the timer interrupt request (IF bit 2) that feeds the CPU `irq` vector beside the joypad (bit 4) and serial (bit 3) sources. It sits directly upstream of `gb_cpu`. Top level ORs `irq_timer` into `irq[2]` and muxes `data_out` into `cpu_data_bus_in` when `hit` is high. Behaviour matches DMG hardware, including the falling-edge increment quirks and the delayed TIMA reload.

## Interface
Parameters:
- `OVF_DELAY`, 4: cpu_clock cycles TIMA reads 0x00 after overflow before reload.

Ports:
- `cpu_clock`  in  1  system clock (T-cycle rate, ~4.19 MHz).
- `rst`  in  1  reset, synchronous, active-high.
- `addr_bus`  in  16  CPU address.
- `data_in`  in  8  CPU write data.
- `we`  in  1  CPU write strobe, sampled on rising `cpu_clock`.
- `data_out`  out  8  read data for FF04–FF07; 0xFF otherwise.
- `hit`  out  1  high when `addr_bus` is in FF04–FF07.
- `irq_timer`  out  1  one-cycle interrupt request pulse.

## Operation
- Internal 16-bit `sys_cnt` increments every cycle, wraps 0xFFFF→0x0000. DIV read = `sys_cnt[15:8]`.
- Any write to FF04 clears `sys_cnt` to 0; data is ignored.
- TAC is 3 bits: [2] enable, [1:0] select. TAC read = {5'b11111, tac}.
- Select maps to a tap bit of `sys_cnt`:
  - 00 → bit 9 (4096 Hz).
  - 01 → bit 3 (262 kHz).
  - 10 → bit 5 (65 kHz).
  - 11 → bit 7 (16 kHz).
- `tick_src = tac[2] & sys_cnt[tap]`. TIMA increments on a 1→0 transition of `tick_src`, compared against its registered previous value.
- The DMG glitches fall out of this edge rule and are required:
  - A DIV write while the tap bit is 1 increments TIMA.
  - Clearing the enable, or changing the select, while `tick_src` is 1 increments TIMA.
- States:
  - RUN: normal counting. An increment of 0xFF sets TIMA to 0x00 and enters DELAY with `dly_cnt = OVF_DELAY-1`.
  - DELAY: TIMA reads 0x00 and does not increment. `dly_cnt` counts down; at 0 the block enters RELOAD. A CPU write to FF05 in DELAY loads the written value, cancels the reload and the irq, and returns to RUN.
  - RELOAD: one cycle. TIMA ← TMA, `irq_timer` = 1, then back to RUN. A TIMA write in this cycle is ignored. A TMA write in this cycle stores the new TMA, and the new value is the one loaded into TIMA.
- A TIMA write in RUN that coincides with an increment edge: the write wins and the increment is dropped.
- TMA is read/write at any time.

## Timing
- Reset values:
  - `sys_cnt` = 0, TIMA = 0, TMA = 0, tac = 0, state = RUN, `irq_timer` = 0.
  - Registered previous `tick_src` = 0.
  - `data_out` follows the address (FF07 reads 0xF8).
- Writes take effect at the rising edge on which `we` is sampled; reads reflect the new value from the next cycle.
- `data_out` and `hit` are combinational from `addr_bus` and the current registers (zero-latency read).
- TIMA updates one cycle after the cycle in which `tick_src` falls.
- Overflow to irq: the edge that wraps TIMA is cycle N. TIMA = 0x00 in cycles N+1…N+OVF_DELAY. The RELOAD cycle is N+OVF_DELAY+1, where TIMA = TMA and `irq_timer` is high for exactly that one cycle.
- `rst` during DELAY or RELOAD aborts immediately: no irq and no reload.

## Structure
- Package `gb_timer_pkg` holds:
  - Address constants `ADDR_DIV`/`ADDR_TIMA`/`ADDR_TMA`/`ADDR_TAC` (FF04–FF07).
  - Typedef `timer_state_t` {RUN, DELAY, RELOAD}.
  - Function `tac_tap(sel)` returning the tap index {9,3,5,7}.
- One sub-module, `gb_div_counter`: the 16-bit `sys_cnt` with clear input, DIV output and selected-tap output.
- TIMA, TMA, TAC, the state machine and the bus decode live in `gb_timer`.

## Test plan
- Reset, then 256 clocks → DIV = 0x01; after 65536 clocks total → DIV = 0x00 (wrap).
- TAC = 0x05, TIMA = 0x00, run 160 clocks → TIMA = 0x0A, no irq.
- TMA = 0xAB, TIMA = 0xFF, TAC = 0x05 → overflow:
  - TIMA reads 0x00 for 4 cycles, then 0xAB.
  - `irq_timer` is high exactly 1 cycle, 5 cycles after the edge.
- Same overflow setup, write TIMA = 0x10 during DELAY → TIMA = 0x10, no reload, `irq_timer` never asserts.
- Glitch edges, each from TAC = 0x05, TIMA = 0x20 with `sys_cnt[3]` = 1:
  - Write FF04 → TIMA = 0x21.
  - Write TAC = 0x01 → TIMA = 0x21.
  - Read FF07 → 0xF9.
- Assert `rst` during DELAY → next cycle TIMA = 0, DIV = 0, TAC read = 0xF8, `irq_timer` stays 0.
